// File: rtl/uart_receiver.sv
// uart_receiver -- 8-bit asynchronous serial receiver, 16x oversampled.
//
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1).
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit / PARITY state).
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   rx_data    last good byte received (held until the next good frame)
//   rx_valid   one-cycle pulse, rx_data valid in that cycle
//   rx_busy    high while a frame is in progress (any state but IDLE)
//   frame_err  one-cycle pulse on a low stop bit
//   parity_err one-cycle pulse on parity mismatch (constant 0 without parity)
module uart_receiver #(
   parameter int BAUD_RATE = 9600,
   parameter int CLK_FREQ  = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       parity_err
);

   // Clamp so a too-fast baud setting still yields a legal divider.
   localparam int          DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
   localparam int          DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam logic [15:0] DIV_M1  = 16'(DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY    = 3'd3,
`endif
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic        rx_meta_q, rx_s_q;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]  samp_cnt_q, samp_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        tick, mid_bit, stop_tick;
`ifdef UART_RX_PARITY_EN
   logic        par_bad_q, par_bad_d;
   logic        parity_err_q, parity_err_d;
`endif

   assign tick      = (tick_cnt_q == DIV_M1);
   // Sixteenth tick of a bit period: centre of the bit, since the
   // start-bit phase already consumed half a bit.
   assign mid_bit   = tick && (samp_cnt_q == 4'd15);
   assign stop_tick = (state_q == S_STOP) && mid_bit;

   // ---------------- state / datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         tick_cnt_q   <= '0;
         samp_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         tick_cnt_q   <= tick_cnt_d;
         samp_cnt_q   <= samp_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
      samp_cnt_d = tick ? samp_cnt_q + 4'd1 : samp_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
`ifdef UART_RX_PARITY_EN
      par_bad_d  = par_bad_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Restart both counters so sampling phase follows the falling edge.
            if (!rx_s_q) begin
               state_d    = S_START;
               tick_cnt_d = '0;
               samp_cnt_d = '0;
            end
         end
         S_START: begin
            if (tick && samp_cnt_q == 4'd7) begin
               samp_cnt_d = '0;
               if (rx_s_q) begin
                  state_d = S_IDLE;       // glitch, silently dropped
               end else begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
               end
            end
         end
         S_DATA: begin
            if (mid_bit) begin
               shift_d[bit_idx_q] = rx_s_q;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (mid_bit) begin
               par_bad_d = rx_s_q ^ (^shift_q);   // even parity over data + bit
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (mid_bit) state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
         end
         S_WAIT_HIGH: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      rx_busy      = (state_q != S_IDLE);
      frame_err_d  = stop_tick && !rx_s_q;
`ifdef UART_RX_PARITY_EN
      parity_err_d = stop_tick && par_bad_q;
      rx_valid_d   = stop_tick && rx_s_q && !par_bad_q;
`else
      rx_valid_d   = stop_tick && rx_s_q;
`endif
      rx_data_d    = rx_valid_d ? shift_q : rx_data_q;
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus random frames,
// expected events queued by the stimulus and checked by a separate monitor.
module tb_uart_receiver;

   localparam int CLK_FREQ  = 1600000;
   localparam int BAUD_RATE = 10000;
   localparam int BIT_CLK   = CLK_FREQ / BAUD_RATE;          // 160
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   // Falling edge to result: start + 8 data (+parity) bits + half stop bit, + 3 clk.
   localparam int LAT = BIT_CLK * (PAR_EN ? 10 : 9) + BIT_CLK / 2 + 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid, rx_busy, frame_err, parity_err;

   uart_receiver #(.BAUD_RATE(BAUD_RATE), .CLK_FREQ(CLK_FREQ)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_busy(rx_busy),
      .frame_err(frame_err), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       valid;
      logic       ferr;
      logic       perr;
      logic [7:0] data;
      int         start_cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] last_good;
   int         checks   = 0;
   int         failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_wait();
      cyc_wait(BIT_CLK);
   endtask

   // Reference model: the outcome of a frame follows from its stop and parity bits.
   task automatic send_frame(input logic [7:0] d, input logic par_bit,
                             input logic stop, input int hold_bits);
      exp_t e;
      logic ok_par;
      ok_par      = !PAR_EN || ((^d) == par_bit);
      e.valid     = stop && ok_par;
      e.ferr      = !stop;
      e.perr      = !ok_par;
      if (e.valid) last_good = d;
      e.data      = last_good;
      e.start_cyc = cyc;
      exp_q.push_back(e);
      rx = 1'b0;
      bit_wait();
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         bit_wait();
      end
      if (PAR_EN) begin
         rx = par_bit;
         bit_wait();
      end
      rx = stop;
      bit_wait();
      if (!stop) begin
         repeat (hold_bits) bit_wait();
         chk("busy_while_line_low", rx_busy, 1);
         rx = 1'b1;
      end
   endtask

   // Monitor: every DUT event must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && (rx_valid || frame_err || parity_err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {29'd0, rx_valid, frame_err, parity_err}, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rx_valid",   rx_valid,   e.valid);
            chk("frame_err",  frame_err,  e.ferr);
            chk("parity_err", parity_err, e.perr);
            chk("rx_data",    rx_data,    e.data);
            chk("busy_at_event", rx_busy, e.ferr);
            chk("latency", cyc - e.start_cyc, LAT);
         end
      end
   end

   task automatic chk_reset_outputs();
      chk("rst_rx_data",    rx_data,    8'h00);
      chk("rst_rx_valid",   rx_valid,   0);
      chk("rst_rx_busy",    rx_busy,    0);
      chk("rst_frame_err",  frame_err,  0);
      chk("rst_parity_err", parity_err, 0);
   endtask

   initial begin
      logic [7:0] d;
      logic       p, s;
      rx        = 1'b1;
      rst_n     = 1'b0;
      last_good = 8'h00;
      cyc_wait(5);
      chk_reset_outputs();
      rst_n = 1'b1;
      cyc_wait(20);

      // single good frame
      send_frame(8'hA5, ^8'hA5, 1'b1, 0);
      cyc_wait(40);
      chk("busy_after_A5", rx_busy, 0);
      chk("hold_A5", rx_data, last_good);

      // back-to-back frames
      send_frame(8'h00, 1'b0, 1'b1, 0);
      send_frame(8'hFF, 1'b0, 1'b1, 0);
      cyc_wait(40);

      // 40-clk glitch on idle line
      rx = 1'b0;
      cyc_wait(40);
      rx = 1'b1;
      cyc_wait(60);
      chk("busy_after_glitch", rx_busy, 0);
      chk("data_after_glitch", rx_data, last_good);

      // bad stop bit, line held low for 3 bit times
      send_frame(8'h3C, ^8'h3C, 1'b0, 2);
      cyc_wait(10);
      chk("busy_after_break", rx_busy, 0);
      chk("data_after_break", rx_data, last_good);
      cyc_wait(20);

      // reset mid-frame after 4 data bits
      d  = 8'hC3;
      rx = 1'b0;
      bit_wait();
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         bit_wait();
      end
      cyc_wait(BIT_CLK / 2);
      rst_n = 1'b0;
      rx    = 1'b1;
      cyc_wait(3);
      chk_reset_outputs();
      last_good = 8'h00;
      rst_n = 1'b1;
      cyc_wait(20);
      send_frame(8'h5A, ^8'h5A, 1'b1, 0);
      cyc_wait(40);

      // parity mismatch then correct resend
      if (PAR_EN) begin
         send_frame(8'h07, 1'b0, 1'b1, 0);
         cyc_wait(20);
         send_frame(8'h07, 1'b1, 1'b1, 0);
         cyc_wait(20);
      end

      // random frames
      for (int n = 0; n < 12; n++) begin
         d = 8'($urandom);
         p = (^d) ^ ($urandom_range(0, 3) == 0);
         s = ($urandom_range(0, 4) != 0);
         send_frame(d, p, s, int'($urandom_range(0, 2)));
         cyc_wait(s ? int'($urandom_range(0, 40)) : int'($urandom_range(5, 40)));
      end

      cyc_wait(LAT + 200);
      chk("pending_events", exp_q.size(), 0);
      chk("final_busy", rx_busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
